rsa_encrypt: RTL

- Computes ciphertext C = M^e mod n on 32-bit operands; it is the encrypt side of the existing RSA decrypt path.
- Uses a level-sensitive compute/done handshake. A single-cycle kickoff latches the operands.
- Runs a fixed-schedule left-to-right square-and-multiply over all exponent bits.
- Each modular multiply is a bit-serial interleaved shift/add/subtract that takes exactly WIDTH cycles, so no wide multiplier or divider is needed.

---
 rtl/rsa_encrypt.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/rsa_encrypt.sv
// rsa_encrypt: computes C = M^e mod n on WIDTH-bit operands.
// The exponent is scanned left to right with a fixed square-and-multiply
// schedule. Each modular multiply is bit-serial: one shift/add/subtract
// iteration per cycle for exactly WIDTH cycles, so there is no wide
// multiplier and no divider.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   compute      level request, sampled in IDLE to start an operation
//   M, e, n      plaintext, public exponent, modulus (latched at start)
//   C            registered ciphertext
//   encrypt_done high while C is valid, held until compute drops
//   busy         high from the operand latch until DONE is entered
module rsa_encrypt #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             compute,
  input  logic [WIDTH-1:0] M,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] C,
  output logic             encrypt_done,
  output logic             busy
);

  localparam int unsigned BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    REDUCE,
    SQUARE,
    MULT,
    DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] e_q;
  logic [WIDTH-1:0] n_q;
  logic [WIDTH-1:0] base_q;
  logic [WIDTH-1:0] result_q;
  // Multiplier operand b, shifted left each cycle so its MSB is the bit in use.
  logic [WIDTH-1:0] mul_b_q;
  logic [WIDTH+1:0] acc_q;
  logic [BW-1:0]    cnt_q;
  logic [BW-1:0]    bit_q;
  logic [WIDTH-1:0] C_q;
  logic             done_q;
  logic             busy_q;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH+1:0] n_ext;
  logic [WIDTH+1:0] acc_d;
  logic [WIDTH-1:0] res;

  assign C            = C_q;
  assign encrypt_done = done_q;
  assign busy         = busy_q;

  // One interleaved modmul iteration. acc < n on entry keeps every
  // intermediate below 2n, so a single conditional subtract suffices.
  always_comb begin
    op_a = '0;
    case (state_q)
      REDUCE:  op_a = WIDTH'(1);
      SQUARE:  op_a = result_q;
      MULT:    op_a = base_q;
      default: op_a = '0;
    endcase
    n_ext = {2'b00, n_q};
    acc_d = acc_q << 1;
    if (acc_d >= n_ext) acc_d = acc_d - n_ext;
    if (mul_b_q[WIDTH-1]) acc_d = acc_d + {2'b00, op_a};
    if (acc_d >= n_ext) acc_d = acc_d - n_ext;
    res = acc_d[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      e_q      <= '0;
      n_q      <= '0;
      base_q   <= '0;
      result_q <= '0;
      mul_b_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      bit_q    <= '0;
      C_q      <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (compute) begin
            e_q     <= e;
            n_q     <= n;
            mul_b_q <= M;
            acc_q   <= '0;
            cnt_q   <= '0;
            if (n < WIDTH'(2)) begin
              C_q     <= '0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              busy_q   <= 1'b1;
              result_q <= WIDTH'(1);
              bit_q    <= LAST;
              state_q  <= REDUCE;
            end
          end
        end

        REDUCE, SQUARE, MULT: begin
          acc_q   <= acc_d;
          mul_b_q <= mul_b_q << 1;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            // Last iteration: commit the product and preload b for the
            // next multiply, whose operand is the value committed now.
            acc_q <= '0;
            cnt_q <= '0;
            case (state_q)
              REDUCE: begin
                base_q  <= res;
                mul_b_q <= result_q;
                state_q <= SQUARE;
              end
              SQUARE: begin
                result_q <= res;
                mul_b_q  <= res;
                if (e_q[bit_q]) begin
                  state_q <= MULT;
                end else if (bit_q == '0) begin
                  C_q     <= res;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= DONE;
                end else begin
                  bit_q <= bit_q - 1'b1;
                end
              end
              default: begin
                result_q <= res;
                mul_b_q  <= res;
                if (bit_q == '0) begin
                  C_q     <= res;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= DONE;
                end else begin
                  bit_q   <= bit_q - 1'b1;
                  state_q <= SQUARE;
                end
              end
            endcase
          end
        end

        DONE: begin
          if (!compute) begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
